// File: rtl/intersection_pkg.sv
// intersection_pkg
// Shared definitions for the junction controller and the traffic_light benches:
// the 2-bit lamp encoding and the controller state enum.
// Feature macro INTERSECTION_PED_EN: the enum always lists PED_WALK, so the
// encoding stays the same in both builds.

package intersection_pkg;

  // Lamp encoding shared with the single traffic_light block (2'b11 unused)
  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;

  typedef enum logic [2:0] {
    ALLRED_A,
    NS_GREEN,
    NS_YELLOW,
    ALLRED_B,
    EW_GREEN,
    EW_YELLOW,
    PED_WALK
  } state_t;

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// phase_timer
// Down-counting phase timer. On load it takes the duration-1 of the phase
// being entered. It then counts down to 0, and "expired" marks the last cycle
// of the phase. While a green is running, green_elapsed gives the number of
// green cycles completed before the current one.
// Ports:
//   clk, rstb      - clock and async active-low reset (count resets to RESET_VAL)
//   load, load_val - reload on state change with the new phase's duration-1
//   count          - current remaining count
//   expired        - count is zero (final cycle of the phase)
//   green_elapsed  - T_GREEN-1-count, only meaningful during a green phase

module phase_timer #(
  parameter int CNT_W     = 8,
  parameter int T_GREEN   = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             expired,
  output logic [CNT_W-1:0] green_elapsed
);

  // Count down and hold at zero. A load always wins, because the owner reloads
  // on every state change and a phase never outlives its zero count.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count <= CNT_W'(RESET_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired       = (count == '0);
  assign green_elapsed = CNT_W'(T_GREEN - 1) - count;

endmodule

// File: rtl/intersection_ctrl.sv
// intersection_ctrl
// Single timing authority for a two-way junction. It sequences NS/EW green,
// yellow and all-red phases. When INTERSECTION_PED_EN is defined, it also
// folds a pedestrian walk phase into the ring, using a level-request /
// pulse-acknowledge handshake.
// Ports:
//   clk       - system clock, rising edge
//   rstb      - asynchronous active-low reset
//   ped_req   - pedestrian request level (ignored when the feature is absent)
//   ns_light  - north-south lamp (00 red, 01 green, 10 yellow)
//   ew_light  - east-west lamp, same encoding
//   walk      - high for the whole walk phase
//   ped_ack   - one-cycle pulse on the first walk cycle
// Macro INTERSECTION_PED_EN: defined enables the pedestrian logic; undefined
// leaves only the base ring, with walk/ped_ack tied low.

module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int T_GREEN     = 8,
  parameter int T_MIN_GREEN = 3,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       ped_req,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk,
  output logic       ped_ack
);

  state_t             state;
  state_t             next_state;
  logic               load;
  logic [CNT_W-1:0]   load_val;
  logic [CNT_W-1:0]   count;
  logic               expired;
  logic [CNT_W-1:0]   green_elapsed;

  logic               walk_due;
  logic               green_cut;
  logic               ret_ew;

  function automatic logic [CNT_W-1:0] phase_len_m1(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   phase_len_m1 = CNT_W'(T_GREEN - 1);
      NS_YELLOW, EW_YELLOW: phase_len_m1 = CNT_W'(T_YELLOW - 1);
      PED_WALK:             phase_len_m1 = CNT_W'(T_WALK - 1);
      default:              phase_len_m1 = CNT_W'(T_ALLRED - 1);
    endcase
  endfunction

  // The timer reloads on every state change, so each phase lasts exactly its
  // duration, even when a green is cut short.
  assign load     = (next_state != state);
  assign load_val = phase_len_m1(next_state);

  phase_timer #(
    .CNT_W     (CNT_W),
    .T_GREEN   (T_GREEN),
    .RESET_VAL (T_ALLRED - 1)
  ) u_timer (
    .clk           (clk),
    .rstb          (rstb),
    .load          (load),
    .load_val      (load_val),
    .count         (count),
    .expired       (expired),
    .green_elapsed (green_elapsed)
  );

`ifdef INTERSECTION_PED_EN
  logic ped_pending;
  logic walk_entry;

  // Walk entry happens only when an all-red phase expires, so checking for a
  // move into PED_WALK is enough.
  assign walk_entry = (next_state == PED_WALK) && (state != PED_WALK);

  // Sticky request flag. A request seen on the entry edge beats the clear, so
  // a held request gets served again at the next all-red.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ped_pending <= 1'b0;
    end else if (ped_req) begin
      ped_pending <= 1'b1;
    end else if (walk_entry) begin
      ped_pending <= 1'b0;
    end
  end

  // Record which green the interrupted all-red was heading for.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ret_ew <= 1'b0;
    end else if (walk_entry) begin
      ret_ew <= (state == ALLRED_B);
    end
  end

  // green_elapsed counts completed cycles, so the current cycle is number
  // green_elapsed+1. Leave once that reaches the minimum.
  assign walk_due  = ped_pending;
  assign green_cut = ped_pending && (green_elapsed >= CNT_W'(T_MIN_GREEN - 1));
`else
  logic ped_unused;

  assign walk_due   = 1'b0;
  assign green_cut  = 1'b0;
  assign ret_ew     = 1'b0;
  assign ped_unused = ^{ped_req, green_elapsed, count};
`endif

  // State register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= ALLRED_A;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: the base ring, with the walk detour out of all-red and the
  // early end of a green.
  always_comb begin
    next_state = state;
    case (state)
      ALLRED_A:  if (expired) next_state = walk_due ? PED_WALK : NS_GREEN;
      NS_GREEN:  if (expired || green_cut) next_state = NS_YELLOW;
      NS_YELLOW: if (expired) next_state = ALLRED_B;
      ALLRED_B:  if (expired) next_state = walk_due ? PED_WALK : EW_GREEN;
      EW_GREEN:  if (expired || green_cut) next_state = EW_YELLOW;
      EW_YELLOW: if (expired) next_state = ALLRED_A;
      PED_WALK:  if (expired) next_state = ret_ew ? EW_GREEN : NS_GREEN;
      default:   next_state = ALLRED_A;
    endcase
  end

  // Moore outputs. The acknowledge uses the freshly loaded timer value to
  // mark the first walk cycle.
  always_comb begin
    ns_light = LIGHT_RED;
    ew_light = LIGHT_RED;
    walk     = 1'b0;
    ped_ack  = 1'b0;
    case (state)
      NS_GREEN:  ns_light = LIGHT_GREEN;
      NS_YELLOW: ns_light = LIGHT_YELLOW;
      EW_GREEN:  ew_light = LIGHT_GREEN;
      EW_YELLOW: ew_light = LIGHT_YELLOW;
`ifdef INTERSECTION_PED_EN
      PED_WALK: begin
        walk    = 1'b1;
        ped_ack = (count == CNT_W'(T_WALK - 1));
      end
`endif
      default: ;
    endcase
  end

endmodule
